// File: rtl/sm_step_ctrl.sv
// Run/step/burst/breakpoint controller that gates the schoolMIPS core clock enable.
// All logic runs on clkIn; smClk and both keys are asynchronous and synchronised here.
module sm_step_ctrl #(
  parameter int DEB_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int BURST_W    = 8
) (
  input  logic               clkIn,
  input  logic               rst,
  input  logic               smClk,
  input  logic               runSw,
  input  logic               stepKey,
  input  logic               burstKey,
  input  logic [BURST_W-1:0] burstLen,
  input  logic               bpEnable,
  input  logic [31:0]        bpValue,
  input  logic [31:0]        regData,
  output logic               clkEnable,
  output logic               halted,
  output logic               bpHit,
  output logic [31:0]        cycleCnt
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BURST} state_e;

  localparam int                 KEY_STEP  = 0;
  localparam int                 KEY_BURST = 1;
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BURST_W-1:0] REM_ONE   = BURST_W'(1);

  logic                    sm_s1_q, sm_s2_q, sm_prev_q, sm_rise;
  logic [1:0]              key_raw, key_s1_q, key_s2_q;
  logic [1:0]              key_lvl_q, key_lvl_d, key_press_q, key_press_d;
  logic [1:0][DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  state_e                  state_q, state_d;
  logic [BURST_W-1:0]      rem_q, rem_d;
  logic                    bp_hit_q, bp_hit_d;
  logic [31:0]             cycle_cnt_q, cycle_cnt_d;
  logic                    clk_en_q;
  logic                    bp_match;

  assign key_raw  = {burstKey, stepKey};
  assign sm_rise  = sm_s2_q & ~sm_prev_q;
  assign bp_match = bpEnable && (regData == bpValue);

  // Debounce: the counter runs only while the synchronised key differs from the
  // accepted level, so any bounce back to the accepted level restarts it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    key_lvl_d   = key_lvl_q;
    key_press_d = '0;
    deb_cnt_d   = deb_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (key_s2_q[k] == key_lvl_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DEB_LAST) begin
        deb_cnt_d[k]   = '0;
        key_lvl_d[k]   = key_s2_q[k];
        key_press_d[k] = key_s2_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    bp_hit_d    = bp_hit_q;
    cycle_cnt_d = cycle_cnt_q;
    if (sm_rise && state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (!runSw) bp_hit_d = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (runSw && !bp_hit_q) begin
          state_d = S_RUN;
        end else if (key_press_q[KEY_STEP]) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end else if (key_press_q[KEY_BURST] && burstLen != '0) begin
          state_d  = S_BURST;
          bp_hit_d = 1'b0;
          rem_d    = burstLen;
        end
      end
      S_RUN: begin
        if (sm_rise && bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (!runSw) begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        if (sm_rise) state_d = S_HALT;
      end
      S_BURST: begin
        if (sm_rise) begin
          rem_d = rem_q - REM_ONE;
          if (bp_match) begin
            state_d  = S_HALT;
            bp_hit_d = 1'b1;
          end else if (rem_q == REM_ONE) begin
            state_d = S_HALT;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      sm_s1_q     <= 1'b0;
      sm_s2_q     <= 1'b0;
      sm_prev_q   <= 1'b0;
      key_s1_q    <= '0;
      key_s2_q    <= '0;
      key_lvl_q   <= '1;  // treat keys as held so one held through reset never yields a press
      key_press_q <= '0;
      deb_cnt_q   <= '0;
      state_q     <= S_HALT;
      rem_q       <= '0;
      bp_hit_q    <= 1'b0;
      cycle_cnt_q <= '0;
      clk_en_q    <= 1'b0;
    end else begin
      sm_s1_q     <= smClk;
      sm_s2_q     <= sm_s1_q;
      sm_prev_q   <= sm_s2_q;
      key_s1_q    <= key_raw;
      key_s2_q    <= key_s1_q;
      key_lvl_q   <= key_lvl_d;
      key_press_q <= key_press_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      bp_hit_q    <= bp_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
      clk_en_q    <= (state_d != S_HALT);
    end
  end

  assign clkEnable = clk_en_q;
  assign halted    = (state_q == S_HALT);
  assign bpHit     = bp_hit_q;
  assign cycleCnt  = cycle_cnt_q;

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Bench for sm_step_ctrl: table of key operations with a scoreboard queue of expected
// counter/flag values, plus hand-written reset, breakpoint, priority and wrap sequences.
module tb_sm_step_ctrl;

  localparam int BURST_W = 8;

  logic               clk_in = 1'b0;
  logic               sm_clk = 1'b0;
  logic               rst;
  logic               run_sw, step_key, burst_key, bp_enable, reg_fb;
  logic [BURST_W-1:0] burst_len;
  logic [31:0]        bp_value;
  logic [31:0]        reg_data;
  logic               clk_enable, halted, bp_hit;
  logic [31:0]        cycle_cnt;

  always #5  clk_in = ~clk_in;
  always #80 sm_clk = ~sm_clk;

  assign reg_data = reg_fb ? cycle_cnt : 32'h0;

  sm_step_ctrl #(.DEB_W(16), .DEB_CYCLES(4), .BURST_W(BURST_W)) dut (
    .clkIn    (clk_in),
    .rst      (rst),
    .smClk    (sm_clk),
    .runSw    (run_sw),
    .stepKey  (step_key),
    .burstKey (burst_key),
    .burstLen (burst_len),
    .bpEnable (bp_enable),
    .bpValue  (bp_value),
    .regData  (reg_data),
    .clkEnable(clk_enable),
    .halted   (halted),
    .bpHit    (bp_hit),
    .cycleCnt (cycle_cnt)
  );

  typedef enum {OP_STEP, OP_GLITCH, OP_BURST, OP_BOTH} op_e;
  typedef struct {
    string name;
    op_e   op;
    int    len;
    int    delta;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] cnt;
    logic        bp;
  } exp_t;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_cnt;
  exp_t        sb_q[$];
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(12);
    model_cnt = 32'd0;
  endtask

  task automatic drive_op(input op_e op, input int len);
    burst_len = BURST_W'(len);
    case (op)
      OP_STEP, OP_GLITCH: step_key = 1'b1;
      OP_BURST:           burst_key = 1'b1;
      default: begin
        step_key  = 1'b1;
        burst_key = 1'b1;
      end
    endcase
    idle(op == OP_GLITCH ? 2 : 10);
    step_key  = 1'b0;
    burst_key = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!(halted && !clk_enable) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check({name, "_reached_halt"}, 32'(halted && !clk_enable), 32'd1);
  endtask

  task automatic expect_push(input string name, input logic bp);
    exp_t e;
    e.name = name;
    e.cnt  = model_cnt;
    e.bp   = bp;
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    e = sb_q.pop_front();
    check({e.name, "_cnt"},    cycle_cnt,         e.cnt);
    check({e.name, "_halted"}, 32'(halted),       32'd1);
    check({e.name, "_clken"},  32'(clk_enable),   32'd0);
    check({e.name, "_bphit"},  32'(bp_hit),       32'(e.bp));
  endtask

  task automatic run_vec(input vec_t v);
    model_cnt = model_cnt + 32'(v.delta);
    expect_push(v.name, 1'b0);
    drive_op(v.op, v.len);
    wait_halt(v.name, 2000);
    idle(40);
    pop_compare();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_total);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"step",   OP_STEP,   0, 1};
    vecs[1] = '{"glitch", OP_GLITCH, 0, 0};
    vecs[2] = '{"burst5", OP_BURST,  5, 5};
    vecs[3] = '{"burst0", OP_BURST,  0, 0};
    vecs[4] = '{"burst1", OP_BURST,  1, 1};
    vecs[5] = '{"step2",  OP_STEP,   0, 1};
    vecs[6] = '{"burst3", OP_BURST,  3, 3};

    rst = 1'b1; run_sw = 1'b0; step_key = 1'b0; burst_key = 1'b0;
    bp_enable = 1'b0; bp_value = 32'd0; burst_len = '0; reg_fb = 1'b0;
    model_cnt = 32'd0;
    #1;
    check("rst_halted", 32'(halted),     32'd1);
    check("rst_clken",  32'(clk_enable), 32'd0);
    check("rst_bphit",  32'(bp_hit),     32'd0);
    check("rst_cnt",    cycle_cnt,       32'd0);
    idle(2);
    rst = 1'b0;
    idle(12);

    // Key held through reset must not produce a press.
    step_key = 1'b1;
    do_reset();
    idle(40);
    check("held_key_halted", 32'(halted), 32'd1);
    check("held_key_cnt",    cycle_cnt,   32'd0);
    step_key = 1'b0;
    idle(12);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a RUN, checked before the next clock edge.
    run_sw = 1'b1;
    idle(40);
    check("run_entered", 32'(halted), 32'd0);
    @(posedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clken",  32'(clk_enable), 32'd0);
    check("async_rst_halted", 32'(halted),     32'd1);
    check("async_rst_cnt",    cycle_cnt,       32'd0);
    run_sw = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(12);
    model_cnt = 32'd0;

    // Breakpoint: the rise that samples regData==7 is still counted, so cycleCnt ends at 8.
    bp_value  = 32'd7;
    bp_enable = 1'b1;
    reg_fb    = 1'b1;
    model_cnt = 32'd8;
    expect_push("bp", 1'b1);
    run_sw = 1'b1;
    idle(4);
    wait_halt("bp", 400);
    idle(2);
    pop_compare();
    idle(40);
    check("bp_hold_halted", 32'(halted), 32'd1);
    check("bp_hold_cnt",    cycle_cnt,   model_cnt);
    check("bp_hold_bphit",  32'(bp_hit), 32'd1);
    run_sw = 1'b0;
    idle(3);
    check("bp_clear_bphit",  32'(bp_hit), 32'd0);
    check("bp_clear_halted", 32'(halted), 32'd1);
    bp_enable = 1'b0;
    run_sw = 1'b1;
    idle(4);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_bphit",  32'(bp_hit), 32'd0);
    run_sw = 1'b0;
    idle(4);
    check("resume_stop_halted", 32'(halted), 32'd1);
    reg_fb = 1'b0;
    do_reset();

    // Both keys accepted in the same cycle: STEP wins.
    run_vec('{"both_keys", OP_BOTH, 5, 1});

    // Step presses during a 20-cycle burst are discarded.
    model_cnt = model_cnt + 32'd20;
    expect_push("burst20", 1'b0);
    drive_op(OP_BURST, 20);
    idle(20);
    repeat (2) begin
      drive_op(OP_STEP, 20);
      idle(20);
    end
    check("burst20_busy", 32'(halted), 32'd0);
    wait_halt("burst20", 2000);
    idle(40);
    pop_compare();

    // Counter wrap.
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    idle(2);
    release dut.cycle_cnt_q;
    idle(1);
    check("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    run_vec('{"wrap_step", OP_STEP, 0, 1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
